// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving the select and registered output of a shared 2:1 mux.
// Define MUX_ARB_TIMEOUT_EN to bound how long one agent may hold the mux while the other waits.
module mux_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic a,
  input  logic b,
  output logic gnt_a,
  output logic gnt_b,
  output logic s,
  output logic y,
  output logic busy
);

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StGntA = 3'b010,
    StGntB = 3'b100
  } state_e;

  state_e state_q, state_d;
  logic   last_a_q;
  logic   s_q;
  logic   y_q;
  logic   hand_a2b;
  logic   hand_b2a;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             sat;

  assign sat      = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign hand_a2b = sat & req_b;
  assign hand_b2a = sat & req_a;

  // Counts consecutive cycles spent in the same grant state; idles at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || (state_q == StIdle)) begin
      cnt_q <= '0;
    end else if (!sat) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign hand_a2b = 1'b0;
  assign hand_b2a = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = last_a_q ? StGntB : StGntA;
        end else if (req_a) begin
          state_d = StGntA;
        end else if (req_b) begin
          state_d = StGntB;
        end
      end
      StGntA: begin
        if (!req_a) begin
          state_d = req_b ? StGntB : StIdle;
        end else if (hand_a2b) begin
          state_d = StGntB;
        end
      end
      StGntB: begin
        if (!req_b) begin
          state_d = req_a ? StGntA : StIdle;
        end else if (hand_b2a) begin
          state_d = StGntA;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Select and data follow the next state so y lines up with the grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_a_q <= 1'b0;
      s_q      <= 1'b0;
      y_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_d)
        StGntA: begin
          last_a_q <= 1'b1;
          s_q      <= 1'b1;
          y_q      <= a;
        end
        StGntB: begin
          last_a_q <= 1'b0;
          s_q      <= 1'b0;
          y_q      <= b;
        end
        default: y_q <= 1'b0;
      endcase
    end
  end

  assign gnt_a = (state_q == StGntA);
  assign gnt_b = (state_q == StGntB);
  assign busy  = gnt_a | gnt_b;
  assign s     = s_q;
  assign y     = y_q;

  a_one_grant: assert property (@(posedge clk) disable iff (rst) !(gnt_a && gnt_b));
  a_hold_range: assert property (@(posedge clk) disable iff (rst)
                                 (HOLD_MAX >= 2) && (HOLD_MAX <= 2 ** CNT_W));

endmodule
